// File: rtl/tb_sdcard_spi_model.sv
// ============================================================================
//  Module   : tb_sdcard_spi_model
//  Purpose  : Behavioural SD card (SPI mode) responder: CMD0/8/55/ACMD41/58/17.
//             Optional CRC7 command checking via macro SDCARD_CRC_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdcard_spi_model #(
    parameter int NCR          = 1,
    parameter int NAC          = 1,
    parameter int INIT_RETRIES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic CS,
    input  logic DI,
    input  logic GND1,
    input  logic GND2,
    input  logic VCC,
    output logic DO
);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_ZERO  = 2'd1,
        S_FRAME = 2'd2,
        S_TX    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        PH_NCR   = 3'd0,
        PH_RESP  = 3'd1,
        PH_NAC   = 3'd2,
        PH_TOKEN = 3'd3,
        PH_DATA  = 3'd4,
        PH_CRC   = 3'd5
    } phase_t;

    state_t       r_state;
    phase_t       r_phase;
    logic [5:0]   r_rx_cnt;
    logic [46:0]  r_shift;
    logic [7:0]   r_tx_byte;
    logic [2:0]   r_bit_cnt;
    logic [9:0]   r_byte_cnt;
    logic [39:0]  r_resp;
    logic [2:0]   r_resp_len;
    logic         r_has_data;
    logic [7:0]   r_base;
    logic [15:0]  r_crc16;
    logic         r_ready;
    logic         r_app;
    logic [15:0]  r_tries;

    logic [47:0]  w_frame;
    logic [5:0]   w_cmd;
    logic         w_in_idle;
    logic         w_crc_ok;
    logic [7:0]   w_r1;
    logic [31:0]  w_payload;
    logic [2:0]   w_len;
    logic         w_data;
    logic         w_set_ready;
    logic         w_inc_try;
    logic         w_go_idle;
    logic         w_app_next;
    logic [39:0]  w_resp;

    assign w_frame   = {r_shift, DI};
    assign w_cmd     = w_frame[45:40];
    assign w_in_idle = ~r_ready;
    assign w_resp    = {w_r1, w_payload};

    logic w_unused_bits;
    assign w_unused_bits = ^{w_frame[47:46], w_frame[39:16], w_frame[7:1], GND1, GND2};

`ifdef SDCARD_CRC_CHECK_EN
    logic [6:0] w_crc7;
    always_comb begin
        w_crc7 = 7'h00;
        for (int i = 47; i >= 8; i--) begin
            w_crc7 = {w_crc7[5:0], 1'b0} ^ ((w_crc7[6] ^ w_frame[i]) ? 7'h09 : 7'h00);
        end
    end
    assign w_crc_ok = (w_crc7 == w_frame[7:1]);
`else
    assign w_crc_ok = 1'b1;
`endif

    // Command decode on the completed frame; state effects are applied at the stop-bit edge
    always_comb begin
        w_r1        = 8'h04 | {7'b0, w_in_idle};
        w_payload   = 32'h0;
        w_len       = 3'd1;
        w_data      = 1'b0;
        w_set_ready = 1'b0;
        w_inc_try   = 1'b0;
        w_go_idle   = 1'b0;
        w_app_next  = 1'b0;
        if (!w_crc_ok) begin
            w_r1       = 8'h08 | {7'b0, w_in_idle};
            w_app_next = r_app;
        end else if (r_app && w_cmd == 6'd41) begin
            if (r_ready) begin
                w_r1 = 8'h00;
            end else if (r_tries < 16'(INIT_RETRIES)) begin
                w_r1      = 8'h01;
                w_inc_try = 1'b1;
            end else begin
                w_r1        = 8'h00;
                w_set_ready = 1'b1;
            end
        end else begin
            case (w_cmd)
                6'd0: begin
                    w_r1      = 8'h01;
                    w_go_idle = 1'b1;
                end
                6'd8: begin
                    w_r1      = {7'b0, w_in_idle};
                    w_payload = {16'h0000, 8'h01, w_frame[15:8]};
                    w_len     = 3'd5;
                end
                6'd55: begin
                    w_r1       = {7'b0, w_in_idle};
                    w_app_next = 1'b1;
                end
                6'd58: begin
                    w_r1      = {7'b0, w_in_idle};
                    w_payload = r_ready ? 32'hC0FF_8000 : 32'h00FF_8000;
                    w_len     = 3'd5;
                end
                6'd17: begin
                    if (r_ready) begin
                        w_r1   = 8'h00;
                        w_data = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [15:0] w_crc_upd;
    logic [9:0]  w_cnt_inc;
    logic [7:0]  w_nx_byte;
    phase_t      w_nx_phase;
    logic [9:0]  w_nx_cnt;
    logic        w_nx_done;
    logic        w_nx_shift;

    assign w_crc_upd = {r_crc16[14:0], 1'b0} ^ ((r_crc16[15] ^ r_tx_byte[7]) ? 16'h1021 : 16'h0000);
    assign w_cnt_inc = r_byte_cnt + 10'd1;

    // Selects the byte that follows the one currently finishing on DO
    always_comb begin
        w_nx_byte  = 8'hFF;
        w_nx_phase = r_phase;
        w_nx_cnt   = w_cnt_inc;
        w_nx_done  = 1'b0;
        w_nx_shift = 1'b0;
        case (r_phase)
            PH_NCR: begin
                if (w_cnt_inc >= 10'(NCR)) begin
                    w_nx_phase = PH_RESP;
                    w_nx_cnt   = 10'd0;
                    w_nx_byte  = r_resp[39:32];
                end
            end
            PH_RESP: begin
                if (w_cnt_inc < {7'b0, r_resp_len}) begin
                    w_nx_byte  = r_resp[31:24];
                    w_nx_shift = 1'b1;
                end else if (!r_has_data) begin
                    w_nx_done = 1'b1;
                end else if (NAC > 0) begin
                    w_nx_phase = PH_NAC;
                    w_nx_cnt   = 10'd0;
                end else begin
                    w_nx_phase = PH_TOKEN;
                    w_nx_cnt   = 10'd0;
                    w_nx_byte  = 8'hFE;
                end
            end
            PH_NAC: begin
                if (w_cnt_inc >= 10'(NAC)) begin
                    w_nx_phase = PH_TOKEN;
                    w_nx_cnt   = 10'd0;
                    w_nx_byte  = 8'hFE;
                end
            end
            PH_TOKEN: begin
                w_nx_phase = PH_DATA;
                w_nx_cnt   = 10'd0;
                w_nx_byte  = r_base;
            end
            PH_DATA: begin
                if (w_cnt_inc < 10'd512) begin
                    w_nx_byte = r_base + w_cnt_inc[7:0];
                end else begin
                    w_nx_phase = PH_CRC;
                    w_nx_cnt   = 10'd0;
                    w_nx_byte  = w_crc_upd[15:8];
                end
            end
            PH_CRC: begin
                if (r_byte_cnt == 10'd0) begin
                    w_nx_byte = r_crc16[7:0];
                end else begin
                    w_nx_done = 1'b1;
                end
            end
            default: w_nx_done = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || !VCC) begin
            DO         <= 1'b1;
            r_state    <= S_HUNT;
            r_phase    <= PH_NCR;
            r_rx_cnt   <= 6'd0;
            r_shift    <= 47'd0;
            r_tx_byte  <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 10'd0;
            r_resp     <= 40'd0;
            r_resp_len <= 3'd0;
            r_has_data <= 1'b0;
            r_base     <= 8'd0;
            r_crc16    <= 16'd0;
            r_ready    <= 1'b0;
            r_app      <= 1'b0;
            r_tries    <= 16'd0;
        end else if (CS) begin
            // Deselect aborts any transfer but keeps the card's init state
            DO         <= 1'b1;
            r_state    <= S_HUNT;
            r_phase    <= PH_NCR;
            r_rx_cnt   <= 6'd0;
            r_shift    <= 47'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 10'd0;
        end else begin
            case (r_state)
                S_HUNT: begin
                    DO <= 1'b1;
                    if (!DI) r_state <= S_ZERO;
                end
                S_ZERO: begin
                    DO <= 1'b1;
                    if (DI) begin
                        r_state  <= S_FRAME;
                        r_shift  <= 47'd1;
                        r_rx_cnt <= 6'd2;
                    end
                end
                S_FRAME: begin
                    DO <= 1'b1;
                    if (r_rx_cnt == 6'd47) begin
                        r_rx_cnt <= 6'd0;
                        r_shift  <= 47'd0;
                        if (w_frame[0]) begin
                            r_app <= w_app_next;
                            if (w_go_idle) begin
                                r_ready <= 1'b0;
                                r_tries <= 16'd0;
                            end else begin
                                if (w_set_ready) r_ready <= 1'b1;
                                if (w_inc_try)   r_tries <= r_tries + 16'd1;
                            end
                            r_resp     <= w_resp;
                            r_resp_len <= w_len;
                            r_has_data <= w_data;
                            r_base     <= w_frame[15:8];
                            r_crc16    <= 16'd0;
                            r_bit_cnt  <= 3'd0;
                            r_byte_cnt <= 10'd0;
                            r_state    <= S_TX;
                            if (NCR > 0) begin
                                r_phase   <= PH_NCR;
                                r_tx_byte <= 8'hFF;
                            end else begin
                                r_phase   <= PH_RESP;
                                r_tx_byte <= w_resp[39:32];
                            end
                        end else begin
                            r_state <= S_HUNT;
                        end
                    end else begin
                        r_shift  <= {r_shift[45:0], DI};
                        r_rx_cnt <= r_rx_cnt + 6'd1;
                    end
                end
                S_TX: begin
                    DO <= r_tx_byte[7];
                    if (r_phase == PH_DATA) r_crc16 <= w_crc_upd;
                    if (r_bit_cnt == 3'd7) begin
                        r_bit_cnt <= 3'd0;
                        if (w_nx_done) begin
                            r_state    <= S_HUNT;
                            r_phase    <= PH_NCR;
                            r_byte_cnt <= 10'd0;
                        end else begin
                            r_tx_byte  <= w_nx_byte;
                            r_phase    <= w_nx_phase;
                            r_byte_cnt <= w_nx_cnt;
                            if (w_nx_shift) r_resp <= {r_resp[31:0], 8'h00};
                        end
                    end else begin
                        r_tx_byte <= {r_tx_byte[6:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tb_sdcard_spi_model.sv
// ============================================================================
//  Module   : tb_tb_sdcard_spi_model
//  Purpose  : Directed plus randomized command sequences against a byte-level card model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_sdcard_spi_model;

    localparam int NCR          = 1;
    localparam int NAC          = 1;
    localparam int INIT_RETRIES = 2;

    logic clk = 1'b0;
    logic rst, cs, di, vcc, sd_do;
    logic gnd = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_blocks = 0;

    logic       m_ready, m_app;
    int         m_tries;
    logic [7:0] exp_q[$];

    tb_sdcard_spi_model #(.NCR(NCR), .NAC(NAC), .INIT_RETRIES(INIT_RETRIES)) dut (
        .CLK(clk), .RST(rst), .CS(cs), .DI(di),
        .GND1(gnd), .GND2(gnd), .VCC(vcc), .DO(sd_do)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            logic fb = c[6] ^ d[i];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            di = f[i];
            tick();
        end
        di = 1'b1;
    endtask

    task automatic send_cmd(input logic [5:0] c, input logic [31:0] a);
        send_frame({2'b01, c, a, crc7({2'b01, c, a}), 1'b1});
    endtask

    task automatic read_byte(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            b = {b[6:0], sd_do};
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_app   = 1'b0;
        m_tries = 0;
    endtask

    // Card behaviour expressed as the byte stream the host should see
    task automatic model_cmd(input logic [5:0] c, input logic [31:0] a);
        logic [7:0]  idle_bit;
        logic [15:0] crc;
        logic [7:0]  d;
        exp_q.delete();
        repeat (NCR) exp_q.push_back(8'hFF);
        idle_bit = m_ready ? 8'h00 : 8'h01;
        if (c == 6'd41 && m_app) begin
            m_app = 1'b0;
            if (m_ready) exp_q.push_back(8'h00);
            else if (m_tries < INIT_RETRIES) begin
                m_tries++;
                exp_q.push_back(8'h01);
            end else begin
                m_ready = 1'b1;
                exp_q.push_back(8'h00);
            end
        end else begin
            m_app = (c == 6'd55);
            case (c)
                6'd0: begin
                    exp_q.push_back(8'h01);
                    m_ready = 1'b0;
                    m_tries = 0;
                end
                6'd8:  exp_q = {exp_q, idle_bit, 8'h00, 8'h00, 8'h01, a[7:0]};
                6'd55: exp_q.push_back(idle_bit);
                6'd58: exp_q = {exp_q, idle_bit, (m_ready ? 8'hC0 : 8'h00), 8'hFF, 8'h80, 8'h00};
                6'd17: begin
                    if (!m_ready) exp_q.push_back(8'h05);
                    else begin
                        exp_q.push_back(8'h00);
                        repeat (NAC) exp_q.push_back(8'hFF);
                        exp_q.push_back(8'hFE);
                        crc = 16'h0000;
                        for (int i = 0; i < 512; i++) begin
                            d = 8'((a[7:0] + i) % 256);
                            exp_q.push_back(d);
                            for (int b = 7; b >= 0; b--) begin
                                logic fb = crc[15] ^ d[b];
                                crc = {crc[14:0], 1'b0};
                                if (fb) crc = crc ^ 16'h1021;
                            end
                        end
                        exp_q.push_back(crc[15:8]);
                        exp_q.push_back(crc[7:0]);
                    end
                end
                default: exp_q.push_back(8'h04 | idle_bit);
            endcase
        end
    endtask

    task automatic expect_resp(input string tag);
        logic [7:0] b;
        foreach (exp_q[i]) begin
            read_byte(b);
            check8(tag, b, exp_q[i]);
        end
        read_byte(b);
        check8({tag, "_idle"}, b, 8'hFF);
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] c, input logic [31:0] a);
        model_cmd(c, a);
        send_cmd(c, a);
        expect_resp(tag);
    endtask

    task automatic partial_block(input string tag, input int nbytes);
        logic [7:0] b;
        model_cmd(6'd17, $urandom);
        send_cmd(6'd17, 32'(exp_q[NCR + NAC + 2]));
        for (int i = 0; i < nbytes; i++) begin
            read_byte(b);
            check8(tag, b, exp_q[i]);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [5:0] c;
        int         r;
        rst = 1'b1; cs = 1'b1; di = 1'b1; vcc = 1'b1;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check8("reset_do", {7'b0, sd_do}, 8'h01);
        cs = 1'b0;
        tick();

        // CMD0 with a zero CRC field: rejected only when CRC checking is built in
        send_frame({2'b01, 6'd0, 32'd0, 7'h00, 1'b1});
        read_byte(b);
        check8("cmd0_badcrc_ncr", b, 8'hFF);
        read_byte(b);
`ifdef SDCARD_CRC_CHECK_EN
        check8("cmd0_badcrc_r1", b, 8'h09);
`else
        check8("cmd0_badcrc_r1", b, 8'h01);
`endif
        run_cmd("cmd0", 6'd0, 32'h0);
        run_cmd("cmd8", 6'd8, 32'h0000_01AA);
        run_cmd("cmd17_idle", 6'd17, 32'h10);
        run_cmd("cmd9_idle", 6'd9, 32'h0);
        run_cmd("cmd41_noapp", 6'd41, 32'h0);

        // CMD55 frame with a zero stop bit must be dropped without arming the app flag
        send_frame({2'b01, 6'd55, 32'd0, crc7({2'b01, 6'd55, 32'd0}), 1'b0});
        read_byte(b);
        check8("badstop_quiet0", b, 8'hFF);
        read_byte(b);
        check8("badstop_quiet1", b, 8'hFF);
        run_cmd("badstop_cmd41", 6'd41, 32'h4000_0000);

        for (int i = 0; i < 3; i++) begin
            run_cmd("cmd55", 6'd55, 32'h0);
            run_cmd("acmd41", 6'd41, 32'h4000_0000);
        end
        run_cmd("cmd58_ready", 6'd58, 32'h0);
        run_cmd("cmd17_blk", 6'd17, 32'h0000_0010);
        run_cmd("cmd9_ready", 6'd9, 32'h0);

        partial_block("cs_abort_data", 20);
        cs = 1'b1;
        repeat (3) tick();
        check8("cs_high_do", {7'b0, sd_do}, 8'h01);
        cs = 1'b0;
        run_cmd("cmd58_after_cs", 6'd58, 32'h0);

        partial_block("rst_abort_data", 10);
        rst = 1'b1;
        tick();
        check8("rst_mid_do", {7'b0, sd_do}, 8'h01);
        rst = 1'b0;
        model_reset();
        run_cmd("cmd58_after_rst", 6'd58, 32'h0);

        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 4)) tick();
            if ($urandom_range(0, 3) == 0) begin
                cs = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                cs = 1'b0;
            end
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin
                    run_cmd("rnd_cmd55", 6'd55, $urandom);
                    c = 6'd41;
                end
                3: c = 6'd8;
                4: c = 6'd58;
                5: c = 6'd17;
                6: c = 6'd9;
                7: c = 6'd41;
                8: c = 6'd13;
                default: begin
                    run_cmd("rnd_cmd55", 6'd55, $urandom);
                    c = 6'd17;
                end
            endcase
            if (c == 6'd17 && m_ready) begin
                if (n_blocks >= 5) c = 6'd58;
                else n_blocks++;
            end
            run_cmd("rnd_cmd", c, $urandom);
        end

        vcc = 1'b0;
        tick();
        check8("unpowered_do", {7'b0, sd_do}, 8'h01);
        vcc = 1'b1;
        model_reset();
        run_cmd("cmd58_after_power", 6'd58, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tb_sdcard_spi_model.md
TB_SDCARD_SPI_MODEL -- requirements
Module: tb_sdcard

Interface
REQ-001 Parameter NCR, default 1: 0xFF filler bytes between a command's stop bit and its response.
REQ-002 Parameter NAC, default 1: 0xFF filler bytes between the CMD17 R1 byte and the 0xFE data token.
REQ-003 Parameter INIT_RETRIES, default 2: ACMD41 attempts answered 0x01 before 0x00 is returned.
REQ-004 CLK  input  1  single clock; also the SPI serial clock; all logic on rising edge.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 CS  input  1  chip select, active-low.
REQ-007 DI  input  1  serial command data from host, MSB first.
REQ-008 GND1, GND2  input  1 each  ground pins; functionally ignored.
REQ-009 VCC  input  1  power; 0 = card unpowered.
REQ-010 DO  output  1  serial response/data to host, MSB first; registered.

Function
REQ-011 DI is sampled and DO updated only on rising CLK edges where CS=0; while CS=1, DO=1 and the bit/byte counters clear, but the card init state is held.
REQ-012 Command receive: skip DI=1 bits; a '0' followed by a '1' starts a 48-bit frame: 0, 1, cmd[5:0], arg[31:0], crc7[6:0], stop bit 1; a stop bit of 0 discards the frame silently.
REQ-013 After the stop-bit edge, DO sends NCR*8 ones, then the response MSB first, one bit per edge, then DO=1 and receive resumes; DI is ignored while any response or data is being sent.
REQ-014 Card state: IDLE after reset/power-up; READY after a successful ACMD41; R1 bit0 (in_idle) = 1 while IDLE.
REQ-015 CMD0: R1 = in_idle; forces IDLE; resets the ACMD41 attempt counter.
REQ-016 CMD8: R7 = R1 then 4 bytes {0x00,0x00,0x01,arg[7:0]} (echo of check pattern).
REQ-017 CMD55: R1; arms the app flag for the next command only.
REQ-018 ACMD41 (CMD41 with app flag): first INIT_RETRIES attempts return 0x01, the next returns 0x00 and enters READY; in READY it returns 0x00.
REQ-019 CMD58: R1 then OCR 0xC0FF8000 in READY, 0x00FF8000 in IDLE.
REQ-020 CMD17 in READY: R1=0x00, NAC*8 ones, token 0xFE, 512 data bytes, CRC16-CCITT (poly 0x1021, init 0) of the data, MSB first; block addressing, data byte i = arg[7:0] + i (mod 256).
REQ-021 CMD17 in IDLE, or any other command, or CMD41 without the app flag: R1 = 0x04 | in_idle; no data follows.
REQ-022 A command other than ACMD41 received after CMD55 clears the app flag and is decoded as a normal command.
REQ-023 CS rising at any point aborts the frame/response/data in progress; the next CS-low period begins in command receive.

Reset
REQ-024 RST=1 or VCC=0 at a rising edge: DO=1, state IDLE, app flag 0, ACMD41 counter 0, all shift registers and counters 0.
REQ-025 Reset during a data block terminates it immediately; the first edge after RST falls is in command receive.

Configuration
REQ-026 Macro SDCARD_CRC_CHECK_EN defined: CRC7 (poly 0x09) over the first 40 bits is checked; on mismatch R1 = 0x08 | in_idle and the command is not executed; not defined: CRC bits are ignored for all commands.

Verification
REQ-027 Reset, CS=0, CMD0 arg 0 crc 0x4A -> after 8 ones, R1 0x01.
REQ-028 CMD8 arg 0x000001AA -> R7 bytes 01 00 00 01 AA.
REQ-029 CMD55+ACMD41 three times -> R1 01, 01, 00; then CMD58 -> 00 C0 FF 80 00.
REQ-030 CMD17 arg 0x00000010 in READY -> 00, FF, FE, data 10 11 12 ... 0F (512 bytes), then the matching 2-byte CRC16.
REQ-031 CMD17 before init -> 0x05; CMD9 -> 0x04/0x05; CS high mid-data, then CMD58 -> correct response.
REQ-032 With SDCARD_CRC_CHECK_EN, CMD0 with crc 0x00 -> 0x09; without the macro -> 0x01.
